// File: rtl/trig_sched_pkg.sv
// rtl/trig_sched_pkg.sv - shared constants and state encoding for the trig scheduler
package trig_sched_pkg;

    localparam int DEG_90       = 90;
    localparam int DEG_360      = 360;
    localparam int NEG_BIAS     = 33120;  // 92*360: lifts any negative 16-bit angle to >= 0
    localparam int REDUCE_STEPS = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/sine.sv
// rtl/sine.sv - combinational sine of an integer angle 0..359 degrees, scaled to +/-32767
module sine #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic [AW-1:0] theta,
    output logic [DW-1:0] value
);

    // Quarter-wave table: round(32767 * sin(k deg)), k = 0..90
    localparam logic [15:0] SIN_TAB [0:90] = '{
        16'd0,     16'd572,   16'd1144,  16'd1715,  16'd2286,  16'd2856,  16'd3425,  16'd3993,  16'd4560,  16'd5126,
        16'd5690,  16'd6252,  16'd6813,  16'd7371,  16'd7927,  16'd8481,  16'd9032,  16'd9580,  16'd10126, 16'd10668,
        16'd11207, 16'd11743, 16'd12275, 16'd12803, 16'd13328, 16'd13848, 16'd14364, 16'd14876, 16'd15383, 16'd15886,
        16'd16384, 16'd16876, 16'd17364, 16'd17846, 16'd18323, 16'd18794, 16'd19260, 16'd19720, 16'd20173, 16'd20621,
        16'd21062, 16'd21497, 16'd21925, 16'd22347, 16'd22762, 16'd23170, 16'd23571, 16'd23964, 16'd24351, 16'd24730,
        16'd25101, 16'd25465, 16'd25821, 16'd26169, 16'd26509, 16'd26841, 16'd27165, 16'd27481, 16'd27788, 16'd28087,
        16'd28377, 16'd28659, 16'd28932, 16'd29196, 16'd29451, 16'd29697, 16'd29934, 16'd30162, 16'd30381, 16'd30591,
        16'd30791, 16'd30982, 16'd31163, 16'd31335, 16'd31498, 16'd31650, 16'd31794, 16'd31927, 16'd32051, 16'd32165,
        16'd32269, 16'd32364, 16'd32448, 16'd32523, 16'd32587, 16'd32642, 16'd32687, 16'd32722, 16'd32747, 16'd32762,
        16'd32767
    };

    // Fold the angle into the first quadrant and apply the sign of its half-turn
    always_comb begin
        logic [6:0]  idx;
        logic        neg;
        logic [15:0] mag;
        if (theta <= AW'(90)) begin
            idx = 7'(theta);
            neg = 1'b0;
        end else if (theta <= AW'(180)) begin
            idx = 7'(AW'(180) - theta);
            neg = 1'b0;
        end else if (theta <= AW'(270)) begin
            idx = 7'(theta - AW'(180));
            neg = 1'b1;
        end else begin
            idx = 7'(AW'(360) - theta);
            neg = 1'b1;
        end
        mag   = (idx <= 7'd90) ? SIN_TAB[idx] : 16'd0;
        value = neg ? DW'(~mag + 16'd1) : DW'(mag);
    end

endmodule

// File: rtl/trig_rr_arb.sv
// rtl/trig_rr_arb.sv - round-robin one-hot grant starting the search at ptr
module trig_rr_arb #(
    parameter int NREQ = 3,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    // First active request at or after ptr, wrapping; only one bit is ever set
    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/trig_sched.sv
// rtl/trig_sched.sv - round-robin scheduler sharing one sine unit with angle reduction
module trig_sched
    import trig_sched_pkg::*;
#(
    parameter  int NREQ = 3,
    parameter  int AW   = 16,
    parameter  int DW   = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*AW-1:0] req_theta,
    input  logic [NREQ-1:0]  req_cos,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [DW-1:0]    rsp_value,
    output logic [8:0]       rsp_theta_norm,
    output logic             busy
);

    localparam int WW = AW + 1;

    state_e          state_q, state_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WW-1:0]   w_q, w_d;
    logic [2:0]      k_q, k_d;
    logic [8:0]      arg_q, arg_d;
    logic [DW-1:0]   rsp_value_q, rsp_value_d;
    logic [8:0]      norm_q, norm_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            accept;
    logic [AW-1:0]   sel_theta;
    logic            sel_cos;
    logic [WW-1:0]   w_load;
    logic [WW-1:0]   step_sub;
    logic [WW-1:0]   w_step;
    logic [DW-1:0]   sine_out;

    trig_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    sine #(
        .AW (AW),
        .DW (DW)
    ) u_sine (
        .theta ({{(AW-9){1'b0}}, arg_q}),
        .value (sine_out)
    );

    // Granted request fields, initial work value and one conditional-subtract step
    always_comb begin
        accept    = (state_q == ST_IDLE) && (grant != '0);
        sel_theta = req_theta[grant_id*AW +: AW];
        sel_cos   = req_cos[grant_id];
        w_load    = {{(WW-AW){sel_theta[AW-1]}}, sel_theta}
                  + (sel_cos ? WW'(DEG_90) : '0)
                  + (sel_theta[AW-1] ? WW'(NEG_BIAS) : '0);
        step_sub  = WW'(DEG_360) << k_q;
        w_step    = (w_q >= step_sub) ? (w_q - step_sub) : w_q;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: one accept, seven reduce steps, one lookup, then wait for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept)       state_d = ST_REDUCE;
            ST_REDUCE: if (k_q == 3'd0)  state_d = ST_LOOKUP;
            ST_LOOKUP:                   state_d = ST_RESP;
            ST_RESP:   if (rsp_ready)    state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; the sine argument register is loaded on the last reduce step
    always_comb begin
        id_d        = id_q;
        rr_ptr_d    = rr_ptr_q;
        w_d         = w_q;
        k_d         = k_q;
        arg_d       = arg_q;
        rsp_value_d = rsp_value_q;
        norm_d      = norm_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
                    w_d      = w_load;
                    k_d      = 3'(REDUCE_STEPS - 1);
                end
            end
            ST_REDUCE: begin
                w_d = w_step;
                if (k_q == 3'd0) arg_d = w_step[8:0];
                else             k_d   = k_q - 3'd1;
            end
            ST_LOOKUP: begin
                rsp_value_d = sine_out;
                norm_d      = arg_q;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q        <= '0;
            rr_ptr_q    <= '0;
            w_q         <= '0;
            k_q         <= '0;
            arg_q       <= '0;
            rsp_value_q <= '0;
            norm_q      <= '0;
        end else begin
            id_q        <= id_d;
            rr_ptr_q    <= rr_ptr_d;
            w_q         <= w_d;
            k_q         <= k_d;
            arg_q       <= arg_d;
            rsp_value_q <= rsp_value_d;
            norm_q      <= norm_d;
        end
    end

    // Outputs: grants only in IDLE and never while reset is asserted
    always_comb begin
        req_ready      = (state_q == ST_IDLE && rst_n) ? grant : '0;
        rsp_valid      = (state_q == ST_RESP);
        busy           = (state_q != ST_IDLE);
        rsp_id         = id_q;
        rsp_value      = rsp_value_q;
        rsp_theta_norm = norm_q;
    end

endmodule

// File: tb/tb_trig_sched.sv
// tb/tb_trig_sched.sv - self-checking bench for trig_sched
module tb_trig_sched;

    localparam int NREQ = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_theta;
    logic [NREQ-1:0]   req_cos;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [DW-1:0]     rsp_value;
    logic [8:0]        rsp_theta_norm;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trig_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_theta      (req_theta),
        .req_cos        (req_cos),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_value      (rsp_value),
        .rsp_theta_norm (rsp_theta_norm),
        .busy           (busy)
    );

    typedef struct {
        int          id;
        logic [15:0] theta;
        bit          cos;
        int          exp_norm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int model_norm(input logic [15:0] th, input bit c);
        int t;
        t = int'($signed(th)) + (c ? 90 : 0);
        t = t % 360;
        if (t < 0) t += 360;
        return t;
    endfunction

    function automatic int model_sin(input int deg);
        real r;
        r = 32767.0 * $sin(real'(deg) * 3.14159265358979 / 180.0);
        return int'(r);
    endfunction

    task automatic check_val(input string name, input logic [15:0] got, input int exp);
        int diff;
        diff = int'($signed(got)) - exp;
        checks++;
        if (diff > 1 || diff < -1) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (+/-1)", name, $signed(got), exp);
        end
    endtask

    // Wait (bounded) until some requester is granted; called just after driving inputs
    task automatic wait_grant(output int gid);
        gid = -1;
        for (int c = 0; c < 60 && gid < 0; c++) begin
            #1;
            if (req_ready != '0) begin
                check("grant_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
            end else begin
                @(posedge clk);
            end
        end
        if (gid < 0) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant expected a grant");
        end
    endtask

    // Step through the accept edge and wait (bounded) for the response
    task automatic finish_txn(input int gid, output int lat, output int got_norm,
                              output logic [15:0] got_val, output int got_id);
        @(posedge clk);
        lat = 1;
        #1;
        req_valid[gid] = 1'b0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        got_norm = int'(rsp_theta_norm);
        got_val  = rsp_value;
        got_id   = int'(rsp_id);
        if (rsp_ready && rsp_valid) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_req(input int i, input logic [15:0] th, input bit c);
        req_theta[i*AW +: AW] = th;
        req_cos[i]            = c;
        req_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, lat, nrm, gid_r;
        logic [15:0] val;
        int seen;
        logic [15:0] r_theta [NREQ];
        bit          r_cos   [NREQ];
        logic [NREQ-1:0] pend;
        int ptr_m, exp_g;

        vecs.push_back('{0, 16'd30,   1'b0, 30});
        vecs.push_back('{0, 16'd390,  1'b0, 30});
        vecs.push_back('{1, 16'hFFC4, 1'b0, 300});
        vecs.push_back('{2, 16'd360,  1'b0, 0});
        vecs.push_back('{0, 16'h8000, 1'b0, 352});
        vecs.push_back('{1, 16'hFE98, 1'b0, 0});
        vecs.push_back('{2, 16'h7FFF, 1'b0, 7});
        vecs.push_back('{0, 16'd0,    1'b1, 90});
        vecs.push_back('{1, 16'd270,  1'b1, 0});
        vecs.push_back('{2, 16'hFFA6, 1'b1, 0});
        vecs.push_back('{0, 16'h7FFF, 1'b1, 97});
        vecs.push_back('{1, 16'd200,  1'b0, 200});

        // Reset state, with requests pending so req_ready must stay low
        rst_n     = 1'b0;
        req_valid = '1;
        req_theta = '0;
        req_cos   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_value", rsp_value, 0);
        check("reset_rsp_norm", rsp_theta_norm, 0);
        req_valid = '0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-request vectors: normalisation, cos offset, boundaries, latency
        foreach (vecs[v]) begin
            apply_req(vecs[v].id, vecs[v].theta, vecs[v].cos);
            wait_grant(g);
            check($sformatf("vec%0d_grant", v), g, vecs[v].id);
            if (g >= 0) begin
                finish_txn(g, lat, nrm, val, gid_r);
                check($sformatf("vec%0d_latency", v), lat, 9);
                check($sformatf("vec%0d_norm", v), nrm, vecs[v].exp_norm);
                check($sformatf("vec%0d_rsp_id", v), gid_r, vecs[v].id);
                check_val($sformatf("vec%0d_value", v), val, model_sin(vecs[v].exp_norm));
            end
            req_valid = '0;
        end

        // Arbitration from rr_ptr=0: all three, then 0 and 2
        do_reset();
        for (int i = 0; i < NREQ; i++) apply_req(i, 16'(10 * (i + 1)), 1'b0);
        for (int k = 0; k < NREQ; k++) begin
            wait_grant(g);
            check($sformatf("arb3_order%0d", k), g, k);
            if (g >= 0) begin
                finish_txn(g, lat, nrm, val, gid_r);
                check($sformatf("arb3_norm%0d", k), nrm, 10 * (k + 1));
            end
        end
        req_valid = '0;
        apply_req(0, 16'd5, 1'b0);
        apply_req(2, 16'd6, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_grant(g);
            check($sformatf("arb2_order%0d", k), g, k * 2);
            if (g >= 0) finish_txn(g, lat, nrm, val, gid_r);
        end
        req_valid = '0;

        // Back-pressure in RESP
        rsp_ready = 1'b0;
        apply_req(0, 16'd45, 1'b0);
        wait_grant(g);
        if (g >= 0) begin
            finish_txn(g, lat, nrm, val, gid_r);
            check("hold_latency", lat, 9);
            apply_req(1, 16'd100, 1'b0);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                check("hold_rsp_valid", rsp_valid, 1);
                check("hold_norm", rsp_theta_norm, 45);
                check("hold_id", rsp_id, 0);
                check_val("hold_value", rsp_value, model_sin(45));
                check("hold_req_ready", req_ready, 0);
                check("hold_busy", busy, 1);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            check("release_rsp_valid", rsp_valid, 0);
            check("release_busy", busy, 0);
            wait_grant(g);
            check("release_next_grant", g, 1);
            if (g >= 0) begin
                finish_txn(g, lat, nrm, val, gid_r);
                check("release_next_norm", nrm, 100);
            end
        end
        req_valid = '0;

        // Reset in the 4th REDUCE cycle
        apply_req(0, 16'd77, 1'b0);
        wait_grant(g);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("midreset_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_rsp_valid", rsp_valid, 0);
        #10;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        check("midreset_no_rsp", seen, 0);
        apply_req(0, 16'd1, 1'b0);
        apply_req(1, 16'd2, 1'b0);
        wait_grant(g);
        check("midreset_ptr_zero", g, 0);
        if (g >= 0) finish_txn(g, lat, nrm, val, gid_r);
        req_valid = '0;

        // Randomized batches against the reference model
        do_reset();
        ptr_m = 0;
        for (int b = 0; b < 15; b++) begin
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                r_theta[i] = 16'($urandom_range(0, 65535));
                r_cos[i]   = 1'($urandom_range(0, 1));
                if (pend[i]) apply_req(i, r_theta[i], r_cos[i]);
            end
            for (int it = 0; it < NREQ + 1 && pend != '0; it++) begin
                exp_g = -1;
                for (int off = NREQ - 1; off >= 0; off--)
                    if (pend[(ptr_m + off) % NREQ]) exp_g = (ptr_m + off) % NREQ;
                wait_grant(g);
                check($sformatf("rnd%0d_grant", b), g, exp_g);
                if (g < 0) break;
                finish_txn(g, lat, nrm, val, gid_r);
                check($sformatf("rnd%0d_latency", b), lat, 9);
                check($sformatf("rnd%0d_rsp_id", b), gid_r, exp_g);
                check($sformatf("rnd%0d_norm", b), nrm, model_norm(r_theta[exp_g], r_cos[exp_g]));
                check_val($sformatf("rnd%0d_value", b), val,
                          model_sin(model_norm(r_theta[exp_g], r_cos[exp_g])));
                pend[exp_g]      = 1'b0;
                req_valid[exp_g] = 1'b0;
                ptr_m            = (exp_g + 1) % NREQ;
            end
            req_valid = '0;
            pend      = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
